// File: rtl/clk_gen_multi.sv
// clk_gen_multi: multi-channel programmable clock-enable generator (square wave + tick per channel).
// Define CLKGEN_SHADOW_DIV_EN to stage divisor writes until the channel's next wrap.
module clk_gen_multi #(
  parameter int NUM_CH = 3,
  parameter int CNT_W = 28,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {28'd100000, 28'd1000000, 28'd33000000}
) (
  input  logic              clock_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_restart,
  input  logic              div_wr,
  input  logic [2:0]        div_sel,
  input  logic [CNT_W-1:0]  div_data,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];
  logic [CNT_W-1:0] act_q [NUM_CH];
  logic [CNT_W-1:0] act_d [NUM_CH];
  logic [NUM_CH-1:0] clk_q, clk_d, tick_q, tick_d, wr_v, wrap_v;
`ifdef CLKGEN_SHADOW_DIV_EN
  logic [CNT_W-1:0] shd_q [NUM_CH];
  logic [CNT_W-1:0] shd_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
`endif
  always_comb begin
    wr_v = '0;
    wrap_v = '0;
    cnt_d = cnt_q;
    act_d = act_q;
    clk_d = clk_q;
    tick_d = '0;
`ifdef CLKGEN_SHADOW_DIV_EN
    shd_d = shd_q;
    pend_d = pend_q;
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      wr_v[c] = div_wr && div_sel == 3'(c);
      // >= lets an immediate divisor shrink below the running count wrap on the next cycle
      wrap_v[c] = en[c] && cnt_q[c] >= act_q[c];
      cnt_d[c] = (sync_restart || wrap_v[c]) ? '0 : cnt_q[c] + CNT_W'(en[c]);
      clk_d[c] = !sync_restart && (clk_q[c] ^ wrap_v[c]);
      tick_d[c] = !sync_restart && wrap_v[c];
`ifdef CLKGEN_SHADOW_DIV_EN
      shd_d[c] = wr_v[c] ? div_data : shd_q[c];
      act_d[c] = (sync_restart && wr_v[c]) ? div_data :
                 (!sync_restart && wrap_v[c] && pend_q[c]) ? shd_q[c] : act_q[c];
      pend_d[c] = (sync_restart && wr_v[c]) ? 1'b0 : wr_v[c] ? 1'b1 :
                  (!sync_restart && wrap_v[c]) ? 1'b0 : pend_q[c];
`else
      act_d[c] = wr_v[c] ? div_data : act_q[c];
`endif
    end
  end
  always_ff @(posedge clock_in) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= '0;
        act_q[c] <= DIV_INIT[c*CNT_W +: CNT_W];
`ifdef CLKGEN_SHADOW_DIV_EN
        shd_q[c] <= DIV_INIT[c*CNT_W +: CNT_W];
`endif
      end
      clk_q <= '0;
      tick_q <= '0;
`ifdef CLKGEN_SHADOW_DIV_EN
      pend_q <= '0;
`endif
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      clk_q <= clk_d;
      tick_q <= tick_d;
`ifdef CLKGEN_SHADOW_DIV_EN
      shd_q <= shd_d;
      pend_q <= pend_d;
`endif
    end
  end
  assign clk_out = clk_q;
  assign tick = tick_q;
endmodule
